stopwatch_timekeeper: RTL and testbench
=======================================

Name: stopwatch_timekeeper

Overview:
- Produces the binary minutes/seconds pair consumed by the stopwatch's seven-segment display driver; it is the source end of that 7-bit minutes/seconds interface.
- Divides the board clock down to a 1 Hz tick and counts MM:SS from 00:00 to 99:59.
- Start/stop and clear are controlled by a small FSM that takes debounced, synchronized button levels.

Parameters:
- TICK_DIV, 50000000, clock cycles per counted second (50 MHz board clock); benches use 4.
- MAX_MINUTES, 99, last minutes value before wrap (two display digits).

Ports:
- clock  input  1  board clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- start_stop  input  1  debounced, synchronized button level; each rising edge toggles run/pause.
- clear  input  1  level, sampled each cycle; high forces 00:00 and stopped.
- minutes  output  7  registered binary minutes, 0..MAX_MINUTES.
- seconds  output  7  registered binary seconds, 0..59.
- running  output  1  high while in RUNNING.
- tick  output  1  one-cycle pulse on the cycle seconds/minutes change.
- rollover  output  1  one-cycle pulse when 99:59 wraps to 00:00 (coincident with tick).

Behaviour:
- Reset (async, on assertion): minutes=0, seconds=0, running=0, tick=0, rollover=0, prescaler=0, state=IDLE. start_stop history register resets to 1, so a button held through reset release is not an edge.
- Edge detect: start_edge = start_stop & ~start_prev; start_prev <= start_stop every cycle.
- FSM states: IDLE (00:00, stopped), RUNNING, PAUSED.
- Transitions:
  - IDLE, start_edge -> RUNNING.
  - RUNNING, start_edge -> PAUSED.
  - PAUSED, start_edge -> RUNNING.
  - Any state, clear=1 -> IDLE.
- clear has priority over start_edge in the same cycle; the edge is discarded.
- Entering IDLE via clear zeroes minutes, seconds and prescaler on that same clock edge.
- running is registered and equals (next state == RUNNING); it rises on the edge that samples start_edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING and holds its value in PAUSED, so resume continues the partial second.
  - When it equals TICK_DIV-1 in RUNNING, the next edge sets it to 0, advances the time and pulses tick.
  - Width is clog2(TICK_DIV).
- Timing: the first tick after a start from IDLE lands exactly TICK_DIV cycles after the start edge is sampled.
- Pause/tick collision: if start_edge arrives in RUNNING on the cycle the prescaler equals TICK_DIV-1, the tick is still taken (time advances, tick pulses) and the state becomes PAUSED with prescaler=0.
- Time advance:
  - seconds < 59: seconds+1.
  - seconds == 59: seconds=0 and minutes+1.
  - 99:59: wraps to 00:00, rollover pulses, and the block stays RUNNING.
- minutes and seconds never take values outside their ranges. No BCD conversion here; the downstream driver converts.
- tick and rollover are low in every cycle except the advance cycle.

Decomposition:
- Package stopwatch_pkg: FSM state encoding (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2), MAX_SECONDS=59, default TICK_DIV.
- One natural sub-module, tick_prescaler (inputs: enable, clear; output: terminal-count pulse; parameter TICK_DIV).
- Edge detect, FSM and MM:SS counters stay in the top.

Test Plan (TICK_DIV=4):
- Reset with start_stop held high, then release reset -> running stays 0, outputs 00:00; a later low->high edge starts counting.
- Start edge at cycle N -> running=1 after edge N; tick and seconds=1 at edge N+4; seconds=2 at N+8.
- Run to 00:59, then one more tick -> seconds=0, minutes=1, tick=1, rollover=0.
- Preload near the end and run to 99:59 plus one tick -> 00:00, tick=1, rollover=1, running stays 1.
- Pause after 2 prescaler counts, hold 10 cycles, resume -> next tick arrives 2 cycles after resume, not 4; time unchanged while paused.
- clear and start_edge in the same cycle while RUNNING at 03:17 -> 00:00, running=0, state IDLE.
- Async reset asserted mid-count between clock edges -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared state encoding and constants for the stopwatch
//                minutes/seconds timekeeper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Control FSM states; IDLE always means 00:00 and stopped
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam logic [6:0] c_MAX_SECONDS      = 7'd59;
    localparam int         c_TICK_DIV_DEFAULT = 50000000;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_timekeeper_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides the board clock to one terminal-count strobe per
//                TICK_DIV enabled cycles. Holds its count while disabled so a
//                paused second resumes where it left off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = c_TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int           c_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(TICK_DIV - 1);

    logic [c_W-1:0] r_count;

    // Count only while enabled; clear wins and restarts the second
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_W'(1);
            end
        end
    end

    assign terminal = enable && (r_count == c_LAST);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/stopwatch_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_timekeeper
//  Description : Start/stop/clear control FSM and binary MM:SS counters that
//                feed the seven-segment display driver. Counts 00:00..99:59
//                at one step per TICK_DIV clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_timekeeper
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV    = c_TICK_DIV_DEFAULT,
    parameter int MAX_MINUTES = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       running,
    output logic       tick,
    output logic       rollover
);

    localparam logic [6:0] c_MAX_MINUTES = 7'(MAX_MINUTES);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_start_prev;
    logic       r_running;
    logic       r_tick;
    logic       r_rollover;
    logic [6:0] r_minutes;
    logic [6:0] r_seconds;
    logic       w_start_edge;
    logic       w_terminal;
    logic       w_advance;

    // History resets high so a button held through reset is not a press
    assign w_start_edge = start_stop & ~r_start_prev;

    // A tick due in the same cycle as a clear is dropped with the time
    assign w_advance = w_terminal & ~clear;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .enable   (r_state == RUNNING),
        .clear    (clear),
        .terminal (w_terminal)
    );

    // Next state: clear beats any button edge arriving in the same cycle
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else if (w_start_edge) begin
            case (r_state)
                IDLE:    w_state_next = RUNNING;
                RUNNING: w_state_next = PAUSED;
                PAUSED:  w_state_next = RUNNING;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // FSM, registered flags and MM:SS counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b1;
            r_running    <= 1'b0;
            r_tick       <= 1'b0;
            r_rollover   <= 1'b0;
            r_minutes    <= 7'd0;
            r_seconds    <= 7'd0;
        end else begin
            r_start_prev <= start_stop;
            r_state      <= w_state_next;
            r_running    <= (w_state_next == RUNNING);
            r_tick       <= w_advance;
            r_rollover   <= 1'b0;
            if (clear) begin
                r_minutes <= 7'd0;
                r_seconds <= 7'd0;
            end else if (w_advance) begin
                if (r_seconds == c_MAX_SECONDS) begin
                    r_seconds <= 7'd0;
                    if (r_minutes == c_MAX_MINUTES) begin
                        r_minutes  <= 7'd0;
                        r_rollover <= 1'b1;
                    end else begin
                        r_minutes <= r_minutes + 7'd1;
                    end
                end else begin
                    r_seconds <= r_seconds + 7'd1;
                end
            end
        end
    end

    assign minutes  = r_minutes;
    assign seconds  = r_seconds;
    assign running  = r_running;
    assign tick     = r_tick;
    assign rollover = r_rollover;

endmodule : stopwatch_timekeeper
`default_nettype wire

// File: tb/tb_stopwatch_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_timekeeper
//  Description : Scoreboard bench for stopwatch_timekeeper. A reference model
//                tracks elapsed time as a plain count of seconds and the
//                cycles spent in the current second; a monitor compares every
//                clocked output against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_timekeeper;

    localparam int c_TICK_DIV = 4;
    localparam int c_MAX_MIN  = 99;
    localparam int c_WRAP     = (c_MAX_MIN + 1) * 60;

    typedef struct {
        int mn;
        int sc;
        bit run;
        bit tk;
        bit ro;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       running;
    logic       tick;
    logic       rollover;

    int   n_vec;
    int   n_bad;
    exp_t q[$];

    // Reference model: time as total seconds, plus cycles into the second
    int m_time;
    int m_phase;
    bit m_running;
    bit m_prev;
    bit m_rolled;

    stopwatch_timekeeper #(
        .TICK_DIV    (c_TICK_DIV),
        .MAX_MINUTES (c_MAX_MIN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .tick       (tick),
        .rollover   (rollover)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: one step per rising clock, pushes the expected outputs
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_time    = 0;
                m_phase   = 0;
                m_running = 1'b0;
                m_prev    = 1'b1;
                q.delete();
            end else begin
                exp_t e;
                bit   press;
                bit   was_run;
                press   = start_stop && !m_prev;
                m_prev  = start_stop;
                e.tk    = 1'b0;
                e.ro    = 1'b0;
                if (clear) begin
                    m_running = 1'b0;
                    m_time    = 0;
                    m_phase   = 0;
                end else begin
                    was_run = m_running;
                    if (was_run) begin
                        if (m_phase == c_TICK_DIV - 1) begin
                            m_phase = 0;
                            m_time  = m_time + 1;
                            e.tk    = 1'b1;
                            if (m_time == c_WRAP) begin
                                m_time   = 0;
                                e.ro     = 1'b1;
                                m_rolled = 1'b1;
                            end
                        end else begin
                            m_phase = m_phase + 1;
                        end
                    end
                    if (press) m_running = !was_run;
                end
                e.mn  = m_time / 60;
                e.sc  = m_time % 60;
                e.run = m_running;
                q.push_back(e);
            end
        end
    end

    // Monitor: compares every clocked output shortly after the edge
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!reset && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec = n_vec + 1;
                if (int'(minutes) != e.mn || int'(seconds) != e.sc ||
                    running != e.run || tick != e.tk || rollover != e.ro) begin
                    n_bad = n_bad + 1;
                    $display("FAIL cycle_out @%0t: got %0d:%0d run=%0b tick=%0b roll=%0b, expected %0d:%0d run=%0b tick=%0b roll=%0b",
                             $time, minutes, seconds, running, tick, rollover,
                             e.mn, e.sc, e.run, e.tk, e.ro);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_vec = n_vec + 1;
        if (minutes !== 7'd0 || seconds !== 7'd0 || running !== 1'b0 ||
            tick !== 1'b0 || rollover !== 1'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d:%0d run=%0b tick=%0b roll=%0b, expected all zero",
                     name, minutes, seconds, running, tick, rollover);
        end
    endtask

    task automatic timeout(input string name);
        n_vec = n_vec + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    task automatic press_button();
        @(negedge clock);
        start_stop = 1'b1;
        @(negedge clock);
        start_stop = 1'b0;
    endtask

    task automatic wait_time(input int target, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (m_time == target) return;
        end
        timeout(name);
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        m_rolled   = 1'b0;
        reset      = 1'b1;
        start_stop = 1'b1;
        clear      = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset_state");
        reset = 1'b0;

        // Button held high through reset release must not start the count
        repeat (6) @(negedge clock);
        start_stop = 1'b0;
        press_button();

        // Run through 00:59 -> 01:00
        wait_time(61, 400, "reach_01_01");

        // Pause one prescaler count into a second, hold, then resume
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clock);
                if (m_running && m_phase == 1) found = 1'b1;
            end
            if (!found) timeout("pause_align");
        end
        start_stop = 1'b1;
        @(negedge clock);
        start_stop = 1'b0;
        repeat (10) @(negedge clock);
        press_button();
        repeat (20) @(negedge clock);

        // Randomized button activity and occasional clears
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
            clear = ($urandom_range(0, 249) == 0);
        end

        // Clear and press together while running at 03:17
        start_stop = 1'b0;
        clear      = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        press_button();
        wait_time(197, 1000, "reach_03_17");
        clear      = 1'b1;
        start_stop = 1'b1;
        @(negedge clock);
        clear      = 1'b0;
        start_stop = 1'b0;
        repeat (8) @(negedge clock);

        // Run all the way to 99:59 and wrap
        m_rolled = 1'b0;
        press_button();
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 25000 && !found; k++) begin
                @(negedge clock);
                if (m_rolled) found = 1'b1;
            end
            if (!found) timeout("reach_rollover");
        end
        repeat (20) @(negedge clock);

        // Asynchronous reset between clock edges
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_stopwatch_timekeeper
`default_nettype wire
